l2_cache: RTL and testbench
===========================

// Module: l2_cache
// PURPOSE
//  Shared, direct-mapped, write-back, write-allocate L2 cache. It serves full-line read and write-back requests.
//  Upstream, it is the L2 port of the coherence bus. Downstream, it drives a main-memory port using the same
//  valid/ready + resp_valid protocol. It handles one request at a time and exposes saturating hit/miss counters.
// PARAMETERS
//  L2_INDEX_BITS  8   log2(number of sets); TAG_BITS = LA - L2_INDEX_BITS
//  CNT_BITS       32  width of each perf counter
//  Widths come from cache.svh: LA = `ADDR_BITS-`OFFSET_BITS (line address), LB = `CACHELINE_BITS.
// PORTS
//  clk             in   1         clock; every flop updates on posedge
//  reset           in   1         synchronous, active-high reset
//  l2_req_valid    in   1         bus request pending; held until l2_req_ready
//  l2_req_ready    out  1         request accepted this cycle (valid & ready)
//  l2_req_addr     in   LA        line address
//  l2_req_rw       in   1         0 = read line, 1 = write back line
//  l2_req_data     in   LB        write-back data
//  l2_resp_valid   out  1         one-cycle pulse carrying read data; reads only
//  l2_resp_data    out  LB        read data; '0 when l2_resp_valid is low
//  mem_req_valid   out  1         memory request; held until mem_req_ready
//  mem_req_ready   in   1         memory accepts the request
//  mem_req_addr    out  LA        memory line address
//  mem_req_rw      out  1         0 = fill read, 1 = eviction write
//  mem_req_data    out  LB        eviction data
//  mem_resp_valid  in   1         fill data valid, one-cycle pulse
//  mem_resp_data   in   LB        fill data
//  l2_hit_cnt      out  CNT_BITS  lookups that hit; saturates at all-ones
//  l2_miss_cnt     out  CNT_BITS  lookups that missed; saturates at all-ones
// BEHAVIOUR
//  Reset: state = IDLE; all valid and dirty bits = 0; both counters = 0; request registers = 0.
//   Every output is 0 in reset, except l2_req_ready, which is 1 in IDLE.
//   Data and tag arrays are not reset.
//  Reset mid-operation aborts the transaction with no response. A late mem_resp_valid is ignored.
//  Index = addr[L2_INDEX_BITS-1:0]; tag = addr[LA-1:L2_INDEX_BITS].
//  FSM states:
//   IDLE       l2_req_ready=1. On valid, latch addr/rw/data -> LOOKUP.
//   LOOKUP     hit = valid[idx] & tag match. Hit increments hit_cnt; miss increments miss_cnt.
//              read hit  -> RESP with the array line.
//              write hit -> write line, set dirty -> IDLE.
//              miss with victim valid & dirty -> EVICT_REQ.
//              clean read miss -> FILL_REQ.
//              clean write miss -> install line (valid=1, dirty=1) -> IDLE.
//   EVICT_REQ  mem_req_valid=1, rw=1, addr={victim tag, idx}, data = victim line.
//              On mem_req_ready: a read goes to FILL_REQ; a write installs its line dirty and goes to IDLE.
//   FILL_REQ   mem_req_valid=1, rw=0, addr = latched addr. On mem_req_ready -> FILL_WAIT.
//   FILL_WAIT  On mem_resp_valid: install the line clean (valid=1, dirty=0), latch the data -> RESP.
//   RESP       l2_resp_valid=1 with the latched line, for exactly one cycle -> IDLE.
//  Latency from acceptance at cycle T:
//   read hit: l2_resp_valid at T+2.
//   write hit: l2_req_ready again at T+2.
//  Simultaneous events and boundaries:
//   l2_req_ready is low in every state except IDLE, so requests are never dropped, only stalled.
//   mem_resp_valid outside FILL_WAIT is ignored.
//   mem_req_valid and its address/data stay stable until mem_req_ready.
//   Counters saturate and never wrap. Exactly one counter changes per lookup.
//   A write hit to a dirty line overwrites it; dirty stays 1.
// STRUCTURE
//  Shared package: l2_state_t enum; TAG_BITS and INDEX helper localparams.
//  Sub-module l2_array: tag/valid/dirty/data storage.
//   Combinational read port, one synchronous write port, synchronous clear of valid/dirty on reset.
// TESTING (L2_INDEX_BITS = 8; memory model answers 3 cycles after acceptance)
//  1. Read 0x0012 after reset -> FILL_REQ addr 0x0012 rw=0.
//     Fill data D0 -> l2_resp_data = D0. miss_cnt=1, hit_cnt=0.
//  2. Read 0x0012 again -> resp D0 at T+2, no mem traffic, hit_cnt=1.
//  3. Write 0x0012 with D1 (hit), then read 0x0112 (same index, new tag).
//     -> eviction rw=1 addr 0x0012 data D1, then fill 0x0112, then resp of the fill data.
//  4. Write miss 0x0034 with D2 on a clean set -> no mem traffic. A later read 0x0034 returns D2.
//  5. Hold mem_req_ready=0 for 10 cycles in EVICT_REQ -> request fields stable, l2_req_ready=0 throughout.
//  6. Assert reset in FILL_WAIT, then pulse mem_resp_valid -> no l2_resp_valid.
//     Next read of the same address misses again.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared types and widths for the L2 cache.
// State enum, line/address widths, tag-width helper.
package l2_cache_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int OFFSET_BITS    = 6;
  localparam int CACHELINE_BITS = 128;

  // Line address and line data widths
  localparam int LA = ADDR_BITS - OFFSET_BITS;
  localparam int LB = CACHELINE_BITS;

  localparam int DEF_INDEX_BITS = 8;
  localparam int DEF_TAG_BITS   = LA - DEF_INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT_REQ,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_RESP
  } l2_state_t;

  function automatic int tag_bits(input int index_bits);
    return LA - index_bits;
  endfunction

endpackage

// File: rtl/l2_array.sv
// Tag/valid/dirty/data storage for the direct-mapped L2.
// Ports: comb read (rd_idx -> valid/dirty/tag/line), one sync write port.
module l2_array #(
  parameter int IDX_BITS  = 8,
  parameter int TAG_BITS  = 18,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_idx,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 wr_dirty
);

  localparam int SETS = 1 << IDX_BITS;

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [SETS];
  logic [LINE_BITS-1:0] line_q [SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = line_q[rd_idx];

  // Every write installs or updates a line, so it is always valid
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      line_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back write-allocate L2, one request at a time.
// Ports: l2_req/l2_resp (bus side), mem_req/mem_resp (memory side), hit/miss counters.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int L2_INDEX_BITS = DEF_INDEX_BITS,
  parameter int CNT_BITS      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l2_req_valid,
  output logic                l2_req_ready,
  input  logic [LA-1:0]       l2_req_addr,
  input  logic                l2_req_rw,
  input  logic [LB-1:0]       l2_req_data,
  output logic                l2_resp_valid,
  output logic [LB-1:0]       l2_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [LA-1:0]       mem_req_addr,
  output logic                mem_req_rw,
  output logic [LB-1:0]       mem_req_data,
  input  logic                mem_resp_valid,
  input  logic [LB-1:0]       mem_resp_data,
  output logic [CNT_BITS-1:0] l2_hit_cnt,
  output logic [CNT_BITS-1:0] l2_miss_cnt
);

  localparam int TAG_BITS = tag_bits(L2_INDEX_BITS);

  l2_state_t state_q, state_d;

  logic [LA-1:0] addr_q;
  logic          rw_q;
  logic [LB-1:0] data_q;
  logic [LB-1:0] line_q;

  logic [L2_INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]      tag;

  logic                v_valid;
  logic                v_dirty;
  logic [TAG_BITS-1:0] v_tag;
  logic [LB-1:0]       v_line;
  logic                hit;

  logic          wr_en;
  logic [LB-1:0] wr_line;
  logic          wr_dirty;

  assign idx = addr_q[L2_INDEX_BITS-1:0];
  assign tag = addr_q[LA-1:L2_INDEX_BITS];
  assign hit = v_valid & (v_tag == tag);

  l2_array #(
    .IDX_BITS  (L2_INDEX_BITS),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (LB)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_valid (v_valid),
    .rd_dirty (v_dirty),
    .rd_tag   (v_tag),
    .rd_line  (v_line),
    .wr_en    (wr_en & ~reset),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_line  (wr_line),
    .wr_dirty (wr_dirty)
  );

  always_comb begin
    state_d       = state_q;
    wr_en         = 1'b0;
    wr_line       = data_q;
    wr_dirty      = 1'b1;
    l2_req_ready  = 1'b0;
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        l2_req_ready = 1'b1;
        if (l2_req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          if (rw_q) begin
            wr_en   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end else if (v_valid & v_dirty) begin
          state_d = S_EVICT_REQ;
        end else if (rw_q) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_FILL_REQ;
        end
      end
      S_EVICT_REQ: begin
        // Victim is still in the array: set is untouched until eviction ends
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {v_tag, idx};
        mem_req_data  = v_line;
        if (mem_req_ready) begin
          if (rw_q) begin
            wr_en   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FILL_REQ;
          end
        end
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        if (mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_resp_valid) begin
          wr_en    = 1'b1;
          wr_line  = mem_resp_data;
          wr_dirty = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        l2_resp_valid = 1'b1;
        l2_resp_data  = line_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      line_q      <= '0;
      l2_hit_cnt  <= '0;
      l2_miss_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && l2_req_valid) begin
        addr_q <= l2_req_addr;
        rw_q   <= l2_req_rw;
        data_q <= l2_req_data;
      end
      if (state_q == S_LOOKUP) begin
        if (hit) begin
          if (!rw_q) line_q <= v_line;
          if (~&l2_hit_cnt)
            l2_hit_cnt <= l2_hit_cnt + CNT_BITS'(1);
        end else if (~&l2_miss_cnt) begin
          l2_miss_cnt <= l2_miss_cnt + CNT_BITS'(1);
        end
      end
      if (state_q == S_FILL_WAIT && mem_resp_valid)
        line_q <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache with a 3-cycle memory model.
// Ports: drives every DUT port; prints one summary line.
module tb_l2_cache;
  import l2_cache_pkg::*;

  localparam logic [LB-1:0] D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_0000;
  localparam logic [LB-1:0] D1 = 128'hD1D1_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
  localparam logic [LB-1:0] D2 = 128'hD2D2_1234_5678_9ABC_DEF0_0F0F_F0F0_0002;
  localparam logic [LB-1:0] D3 = 128'hD3D3_CAFE_BABE_DEAD_BEEF_0123_4567_0003;
  localparam logic [LB-1:0] D4 = 128'hD4D4_5A5A_A5A5_3C3C_C3C3_9696_6969_0004;
  localparam logic [LB-1:0] D5 = 128'hD5D5_0BAD_F00D_1357_2468_ACE0_BDF1_0005;
  localparam logic [LB-1:0] D6 = 128'hD6D6_7777_8888_9999_AAAA_BBBB_CCCC_0006;
  localparam logic [LB-1:0] D7 = 128'hD7D7_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_0007;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          l2_req_valid = 1'b0;
  logic          l2_req_ready;
  logic [LA-1:0] l2_req_addr = '0;
  logic          l2_req_rw = 1'b0;
  logic [LB-1:0] l2_req_data = '0;
  logic          l2_resp_valid;
  logic [LB-1:0] l2_resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [LA-1:0] mem_req_addr;
  logic          mem_req_rw;
  logic [LB-1:0] mem_req_data;
  logic          mem_resp_valid;
  logic [LB-1:0] mem_resp_data;
  logic [31:0]   l2_hit_cnt;
  logic [31:0]   l2_miss_cnt;

  logic          mem_hold = 1'b0;
  logic          auto_resp = 1'b1;
  logic [LB-1:0] fill_data = '0;
  logic          model_resp = 1'b0;
  logic [LB-1:0] model_data = '0;
  logic          tb_resp = 1'b0;
  logic [LB-1:0] tb_data = '0;
  int            pend = 0;
  int            cyc = 0;
  int            nreq = 0;
  logic [LA-1:0] log_addr [16];
  logic          log_rw   [16];
  logic [LB-1:0] log_data [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_req_ready  = ~mem_hold;
  assign mem_resp_valid = model_resp | tb_resp;
  assign mem_resp_data  = tb_resp ? tb_data : model_data;

  l2_cache #(
    .L2_INDEX_BITS (8),
    .CNT_BITS      (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .l2_req_valid   (l2_req_valid),
    .l2_req_ready   (l2_req_ready),
    .l2_req_addr    (l2_req_addr),
    .l2_req_rw      (l2_req_rw),
    .l2_req_data    (l2_req_data),
    .l2_resp_valid  (l2_resp_valid),
    .l2_resp_data   (l2_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_rw     (mem_req_rw),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .l2_hit_cnt     (l2_hit_cnt),
    .l2_miss_cnt    (l2_miss_cnt)
  );

  // Memory model: logs accepted requests, answers fills 3 cycles later
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    model_resp <= 1'b0;
    if (pend == 1) begin
      model_resp <= 1'b1;
      model_data <= fill_data;
      pend       <= 0;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end
    if (mem_req_valid && mem_req_ready) begin
      if (nreq < 16) begin
        log_addr[nreq] <= mem_req_addr;
        log_rw[nreq]   <= mem_req_rw;
        log_data[nreq] <= mem_req_data;
      end
      nreq <= nreq + 1;
      if (!mem_req_rw && auto_resp) pend <= 2;
    end
  end

  task automatic chk(input string tag,
                     input logic [LB-1:0] got,
                     input logic [LB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [LA-1:0] a,
                        input logic rw,
                        input logic [LB-1:0] d,
                        output int t);
    logic ok;
    ok = 1'b0;
    t  = -1;
    @(negedge clk);
    l2_req_valid = 1'b1;
    l2_req_addr  = a;
    l2_req_rw    = rw;
    l2_req_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (l2_req_ready) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("accept", LB'(ok), LB'(1));
    @(negedge clk);
    l2_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [LB-1:0] d, output int tc);
    d  = '0;
    tc = -1;
    for (int i = 0; i < 60; i++) begin
      if (l2_resp_valid) begin
        d  = l2_resp_data;
        tc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output int tc);
    tc = -1;
    for (int i = 0; i < 60; i++) begin
      if (l2_req_ready) begin
        tc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int t;
    int tc;
    int n0;
    logic [LB-1:0] d;
    logic saw;

    repeat (3) @(negedge clk);
    chk("rst ready", LB'(l2_req_ready), LB'(1));
    chk("rst memv", LB'(mem_req_valid), LB'(0));
    chk("rst respv", LB'(l2_resp_valid), LB'(0));
    chk("rst hit", LB'(l2_hit_cnt), LB'(0));
    chk("rst miss", LB'(l2_miss_cnt), LB'(0));
    reset = 1'b0;

    // 1: cold read miss -> fill
    fill_data = D0;
    do_req(26'h0012, 1'b0, '0, t);
    wait_resp(d, tc);
    chk("t1 data", d, D0);
    chk("t1 nreq", LB'(nreq), LB'(1));
    chk("t1 maddr", LB'(log_addr[0]), LB'(26'h0012));
    chk("t1 mrw", LB'(log_rw[0]), LB'(0));
    chk("t1 miss", LB'(l2_miss_cnt), LB'(1));
    chk("t1 hit", LB'(l2_hit_cnt), LB'(0));

    // 2: read hit
    n0 = nreq;
    do_req(26'h0012, 1'b0, '0, t);
    wait_resp(d, tc);
    chk("t2 data", d, D0);
    chk("t2 lat", LB'(tc - t), LB'(2));
    chk("t2 nreq", LB'(nreq), LB'(n0));
    chk("t2 hit", LB'(l2_hit_cnt), LB'(1));

    // 3: write hit, then conflicting read evicts dirty line
    do_req(26'h0012, 1'b1, D1, t);
    wait_ready(tc);
    chk("t3 wlat", LB'(tc - t), LB'(2));
    chk("t3 hit", LB'(l2_hit_cnt), LB'(2));
    n0 = nreq;
    fill_data = D3;
    do_req(26'h0112, 1'b0, '0, t);
    wait_resp(d, tc);
    chk("t3 data", d, D3);
    chk("t3 nreq", LB'(nreq), LB'(n0 + 2));
    chk("t3 ev rw", LB'(log_rw[n0]), LB'(1));
    chk("t3 ev addr", LB'(log_addr[n0]), LB'(26'h0012));
    chk("t3 ev data", log_data[n0], D1);
    chk("t3 f rw", LB'(log_rw[n0+1]), LB'(0));
    chk("t3 f addr", LB'(log_addr[n0+1]), LB'(26'h0112));
    chk("t3 miss", LB'(l2_miss_cnt), LB'(2));

    // 4: clean write miss installs locally
    n0 = nreq;
    do_req(26'h0034, 1'b1, D2, t);
    wait_ready(tc);
    do_req(26'h0034, 1'b0, '0, t);
    wait_resp(d, tc);
    chk("t4 data", d, D2);
    chk("t4 lat", LB'(tc - t), LB'(2));
    chk("t4 nreq", LB'(nreq), LB'(n0));
    chk("t4 miss", LB'(l2_miss_cnt), LB'(3));
    chk("t4 hit", LB'(l2_hit_cnt), LB'(3));

    // 5: stalled eviction keeps request stable
    do_req(26'h0112, 1'b1, D4, t);
    wait_ready(tc);
    chk("t5 hit", LB'(l2_hit_cnt), LB'(4));
    mem_hold  = 1'b1;
    fill_data = D5;
    n0 = nreq;
    do_req(26'h0212, 1'b0, '0, t);
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      chk("t5 ctl",
          LB'({mem_req_valid, mem_req_rw, mem_req_addr, l2_req_ready}),
          LB'({1'b1, 1'b1, 26'h0112, 1'b0}));
      chk("t5 data", mem_req_data, D4);
      @(negedge clk);
    end
    mem_hold = 1'b0;
    wait_resp(d, tc);
    chk("t5 resp", d, D5);
    chk("t5 ev rw", LB'(log_rw[n0]), LB'(1));
    chk("t5 ev addr", LB'(log_addr[n0]), LB'(26'h0112));
    chk("t5 ev data", log_data[n0], D4);
    chk("t5 f addr", LB'(log_addr[n0+1]), LB'(26'h0212));
    chk("t5 miss", LB'(l2_miss_cnt), LB'(4));

    // 6: reset during fill wait, then a late fill response
    auto_resp = 1'b0;
    n0 = nreq;
    do_req(26'h0056, 1'b0, '0, t);
    for (int i = 0; i < 20; i++) begin
      if (nreq == n0 + 1) break;
      @(negedge clk);
    end
    chk("t6 fillreq", LB'(nreq), LB'(n0 + 1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("t6 hit", LB'(l2_hit_cnt), LB'(0));
    chk("t6 miss", LB'(l2_miss_cnt), LB'(0));
    chk("t6 ready", LB'(l2_req_ready), LB'(1));
    tb_data = D7;
    tb_resp = 1'b1;
    @(negedge clk);
    tb_resp = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      saw |= l2_resp_valid;
      @(negedge clk);
    end
    chk("t6 noresp", LB'(saw), LB'(0));
    auto_resp = 1'b1;
    fill_data = D6;
    n0 = nreq;
    do_req(26'h0056, 1'b0, '0, t);
    wait_resp(d, tc);
    chk("t6 data", d, D6);
    chk("t6 nreq2", LB'(nreq), LB'(n0 + 1));
    chk("t6 miss2", LB'(l2_miss_cnt), LB'(1));
    chk("t6 hit2", LB'(l2_hit_cnt), LB'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
